// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - match scoring, serve delay and game-over banner handshake
// Optional WIN_BY_TWO_EN: a win also needs a two-point lead, with scores saturating at the register limit.
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_CYCLES = 50000000,
  parameter int SERVE_W      = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               point_p1,
  input  logic               point_p2,
  input  logic               go_done,
  input  logic               restart,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               play_en,
  output logic               go_enable,
  output logic               winner,
  output logic               go_clear
);

  typedef enum logic [1:0] {SERVE, PLAY, BANNER, OVER_HOLD} state_t;

  localparam logic [SCORE_W-1:0] L_WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] L_ONE        = SCORE_W'(1);
  localparam logic [SERVE_W-1:0] L_SERVE_LAST = SERVE_W'(SERVE_CYCLES - 1);
  localparam logic [SERVE_W-1:0] L_CNT_ONE    = SERVE_W'(1);

  state_t             r_state, w_next_state;
  logic [SERVE_W-1:0] r_serve_cnt, w_next_cnt;
  logic [SCORE_W-1:0] r_s1, r_s2, w_s1, w_s2;
  logic               r_winner, w_winner;
  logic               r_play_en, r_go_enable, r_go_clear, w_go_clear;
  // Candidate scores if p1 (c1_*) or p2 (c2_*) takes the point this cycle
  logic [SCORE_W-1:0] w_c1_p1, w_c1_p2, w_c2_p1, w_c2_p2;
  logic               w_p1_win, w_p2_win;

`ifdef WIN_BY_TWO_EN
  localparam logic [SCORE_W-1:0] L_MAX = '1;
  localparam logic [SCORE_W:0]   L_TWO = (SCORE_W+1)'(2);

  always_comb begin
    w_c1_p1 = r_s1 + L_ONE;
    w_c1_p2 = r_s2;
    w_c2_p1 = r_s1;
    w_c2_p2 = r_s2 + L_ONE;
    if (r_s1 == L_MAX) begin
      w_c1_p1 = r_s1;
      w_c1_p2 = r_s2 - L_ONE;
    end
    if (r_s2 == L_MAX) begin
      w_c2_p2 = r_s2;
      w_c2_p1 = r_s1 - L_ONE;
    end
    w_p1_win = (w_c1_p1 >= L_WIN) && ({1'b0, w_c1_p1} >= ({1'b0, w_c1_p2} + L_TWO));
    w_p2_win = (w_c2_p2 >= L_WIN) && ({1'b0, w_c2_p2} >= ({1'b0, w_c2_p1} + L_TWO));
  end
`else
  always_comb begin
    w_c1_p1  = r_s1 + L_ONE;
    w_c1_p2  = r_s2;
    w_c2_p1  = r_s1;
    w_c2_p2  = r_s2 + L_ONE;
    w_p1_win = (w_c1_p1 == L_WIN);
    w_p2_win = (w_c2_p2 == L_WIN);
  end
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = '0;
    w_s1         = r_s1;
    w_s2         = r_s2;
    w_winner     = r_winner;
    w_go_clear   = 1'b0;
    case (r_state)
      SERVE: begin
        if (r_serve_cnt == L_SERVE_LAST) w_next_state = PLAY;
        else                             w_next_cnt   = r_serve_cnt + L_CNT_ONE;
      end
      PLAY: begin
        // Simultaneous pulses are a tie and award nothing
        if (point_p1 && !point_p2) begin
          w_s1 = w_c1_p1;
          w_s2 = w_c1_p2;
          if (w_p1_win) begin
            w_next_state = BANNER;
            w_winner     = 1'b1;
          end else begin
            w_next_state = SERVE;
          end
        end else if (point_p2 && !point_p1) begin
          w_s1 = w_c2_p1;
          w_s2 = w_c2_p2;
          if (w_p2_win) begin
            w_next_state = BANNER;
            w_winner     = 1'b0;
          end else begin
            w_next_state = SERVE;
          end
        end
      end
      BANNER: begin
        if (go_done) w_next_state = OVER_HOLD;
      end
      OVER_HOLD: begin
        if (restart) begin
          w_s1         = '0;
          w_s2         = '0;
          w_winner     = 1'b0;
          w_go_clear   = 1'b1;
          w_next_state = SERVE;
        end
      end
      default: w_next_state = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SERVE;
      r_serve_cnt <= '0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_winner    <= 1'b0;
      r_play_en   <= 1'b0;
      r_go_enable <= 1'b0;
      r_go_clear  <= 1'b1;
    end else begin
      r_state     <= w_next_state;
      r_serve_cnt <= w_next_cnt;
      r_s1        <= w_s1;
      r_s2        <= w_s2;
      r_winner    <= w_winner;
      r_play_en   <= (w_next_state == PLAY);
      // Follows the BANNER state one cycle late, so enable trails the winning point by two cycles
      r_go_enable <= (r_state == BANNER) && !go_done;
      r_go_clear  <= w_go_clear;
    end
  end

  assign score_p1  = r_s1;
  assign score_p2  = r_s2;
  assign play_en   = r_play_en;
  assign go_enable = r_go_enable;
  assign winner    = r_winner;
  assign go_clear  = r_go_clear;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - scoreboard bench for score_keeper (SERVE_CYCLES=4)
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset, point_p1, point_p2, go_done, restart;
  logic [3:0] score_p1, score_p2;
  logic       play_en, go_enable, winner, go_clear;

  score_keeper #(.WIN_SCORE(7), .SCORE_W(4), .SERVE_CYCLES(4), .SERVE_W(3)) dut (
    .clk(clk), .reset(reset), .point_p1(point_p1), .point_p2(point_p2),
    .go_done(go_done), .restart(restart), .score_p1(score_p1), .score_p2(score_p2),
    .play_en(play_en), .go_enable(go_enable), .winner(winner), .go_clear(go_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [11:0] v;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  logic [11:0] prev = 'x;
  logic [11:0] vec;

  assign vec = {score_p1, score_p2, play_en, go_enable, winner, go_clear};

  function automatic logic [11:0] mk(int s1, int s2, bit pe, bit ge, bit w, bit gc);
    return {4'(s1), 4'(s2), pe, ge, w, gc};
  endfunction

  function automatic void push(int c, logic [11:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: every change of the output vector must match the next expected event
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (mon_en && (vec !== prev)) begin
      prev = vec;
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, vec);
      end else begin
        e = q.pop_front();
        if ((e.cyc != cyc) || (e.v !== vec)) begin
          n_bad++;
          $display("FAIL out_event cyc=%0d got=%h required=%h at cyc %0d", cyc, vec, e.v, e.cyc);
        end
      end
    end
  end

  // Point pulse issued in PLAY; returns in PLAY (next serve done) or two cycles into BANNER
  task automatic pt(input bit a, input bit b, input int e1, input int e2, input bit ends, input bit w);
    int c;
    c = cyc;
    point_p1 = a;
    point_p2 = b;
    if (ends) begin
      push(c + 1, mk(e1, e2, 0, 0, w, 0));
      push(c + 2, mk(e1, e2, 0, 1, w, 0));
    end else begin
      push(c + 1, mk(e1, e2, 0, 0, 0, 0));
      push(c + 5, mk(e1, e2, 1, 0, 0, 0));
    end
    @(negedge clk);
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    repeat (ends ? 1 : 4) @(negedge clk);
  endtask

  initial begin
    int c;
    reset = 1'b1; point_p1 = 1'b0; point_p2 = 1'b0; go_done = 1'b0; restart = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    push(cyc + 1, mk(0, 0, 0, 0, 0, 1));
    @(negedge clk);
    c = cyc;
    reset = 1'b0;
    push(c + 1, mk(0, 0, 0, 0, 0, 0));
    push(c + 4, mk(0, 0, 1, 0, 0, 0));
    repeat (4) @(negedge clk);

    // Stray restart, go_done and a tied point in PLAY change nothing
    restart = 1'b1;
    @(negedge clk); restart = 1'b0; go_done = 1'b1;
    @(negedge clk); go_done = 1'b0; point_p1 = 1'b1; point_p2 = 1'b1;
    @(negedge clk); point_p1 = 1'b0; point_p2 = 1'b0;
    repeat (2) @(negedge clk);

    // First point, with a p2 pulse landing in SERVE that must be ignored
    c = cyc;
    point_p1 = 1'b1;
    push(c + 1, mk(1, 0, 0, 0, 0, 0));
    push(c + 5, mk(1, 0, 1, 0, 0, 0));
    @(negedge clk); point_p1 = 1'b0; point_p2 = 1'b1;
    @(negedge clk); point_p2 = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 2; i <= 7; i++) pt(1'b1, 1'b0, i, 0, (i == 7), (i == 7));

    // Banner handshake: go_done held three cycles, then stray point, then restart
    c = cyc;
    go_done = 1'b1;
    push(c + 1, mk(7, 0, 0, 0, 1, 0));
    repeat (3) @(negedge clk);
    go_done = 1'b0;
    point_p1 = 1'b1;
    @(negedge clk); point_p1 = 1'b0;
    @(negedge clk);
    c = cyc;
    restart = 1'b1;
    push(c + 1, mk(0, 0, 0, 0, 0, 1));
    push(c + 2, mk(0, 0, 0, 0, 0, 0));
    push(c + 5, mk(0, 0, 1, 0, 0, 0));
    @(negedge clk); restart = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 1; i <= 7; i++) pt(1'b0, 1'b1, 0, i, (i == 7), 1'b0);

    // Reset while the banner is enabled
    c = cyc;
    reset = 1'b1;
    push(c + 1, mk(0, 0, 0, 0, 0, 1));
    push(c + 2, mk(0, 0, 0, 0, 0, 0));
    push(c + 5, mk(0, 0, 1, 0, 0, 0));
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);

`ifdef WIN_BY_TWO_EN
    for (int i = 1; i <= 6; i++) pt(1'b1, 1'b0, i, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) pt(1'b0, 1'b1, 6, i, 1'b0, 1'b0);
    pt(1'b0, 1'b1, 6, 7, 1'b0, 1'b0);
    pt(1'b0, 1'b1, 6, 8, 1'b1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events got=%0d outstanding required=0 (next at cyc %0d)", q.size(), q[0].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
